// File: rtl/soc_system_ram_fpga_arbiter_pkg.sv
// Shared types and constants for the FPGA on-chip RAM round-robin arbiter.
package soc_ram_arb_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BE_W      = 4;
  localparam int unsigned AW_DEF    = 15;
  localparam int unsigned DEPTH_DEF = 25000;
  localparam int unsigned ID_W      = 2;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            is_read;
    logic            oob;
  } rd_tag_t;

  // Rotating priority distance of requester j when the last winner was 'last'.
  function automatic int unsigned rr_dist(input int unsigned j, input int unsigned last,
                                          input int unsigned n);
    return (j + n - last - 1) % n;
  endfunction

endpackage

// File: rtl/soc_system_ram_fpga_arbiter_if.sv
// Requester-side bus of the RAM arbiter: request fields in, grant/return out.
interface soc_system_ram_fpga_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned AW      = 15
);
  import soc_ram_arb_pkg::*;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ*AW-1:0]     addr;
  logic [NUM_REQ*BE_W-1:0]   be;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [NUM_REQ-1:0]        rerr;
  logic [DATA_W-1:0]         rdata;

  modport master (
    output req, we, lock, addr, be, wdata,
    input  gnt, rvalid, rerr, rdata
  );

  modport slave (
    input  req, we, lock, addr, be, wdata,
    output gnt, rvalid, rerr, rdata
  );

endinterface

// File: rtl/soc_system_ram_fpga_arbiter_picker.sv
// Combinational rotate-priority picker: first requester after 'last' wins.
module soc_ram_rr_picker
  import soc_ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  output logic [ID_W-1:0]    idx_o,
  output logic               valid_o
);

  int unsigned best_d;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    best_d  = NUM_REQ;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (req_i[j] && (rr_dist(j, 32'(last_i), NUM_REQ) < best_d)) begin
        best_d  = rr_dist(j, 32'(last_i), NUM_REQ);
        idx_o   = ID_W'(j);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/soc_system_ram_fpga_arbiter.sv
// Round-robin arbiter with lock bursts, out-of-range guard and read-return
// routing in front of one port of the on-chip FPGA RAM (1-cycle read latency).
module soc_system_ram_fpga_arbiter
  import soc_ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  soc_system_ram_fpga_arbiter_if.slave bus,
  output logic [AW-1:0]                ram_address,
  output logic [BE_W-1:0]              ram_byteenable,
  output logic                         ram_chipselect,
  output logic                         ram_write,
  output logic [DATA_W-1:0]            ram_writedata,
  input  logic [DATA_W-1:0]            ram_readdata
);

  localparam int unsigned   HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

  logic [ID_W-1:0] last_q, last_d;
  logic            owner_q, owner_d;
  logic [HW-1:0]   hold_q, hold_d;
  rd_tag_t         tag_q, tag_d;
  logic            tag_vld_q, tag_vld_d;

  logic [ID_W-1:0]    rr_idx;
  logic               rr_vld;
  logic               own_lock_req;
  logic               others_pending;
  logic               lock_win;
  logic [ID_W-1:0]    win;
  logic               win_vld;
  logic [NUM_REQ-1:0] gnt;
  logic [AW-1:0]      sel_addr;
  logic [BE_W-1:0]    sel_be;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_we;
  logic               sel_oob;

  soc_ram_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i   (bus.req),
    .last_i  (last_q),
    .idx_o   (rr_idx),
    .valid_o (rr_vld)
  );

  // Lock precedence only applies when the last owner was actually granted last cycle.
  always_comb begin
    own_lock_req   = 1'b0;
    others_pending = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == last_q) begin
        own_lock_req = bus.req[j] & bus.lock[j];
      end else begin
        others_pending = others_pending | bus.req[j];
      end
    end
    lock_win = owner_q & own_lock_req & ((hold_q < HOLD_LIM) | ~others_pending);
    win      = lock_win ? last_q : rr_idx;
    win_vld  = lock_win | rr_vld;
  end

  always_comb begin
    gnt       = '0;
    sel_addr  = '0;
    sel_be    = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == win) begin
        gnt[j]    = win_vld;
        sel_addr  = bus.addr[j*AW +: AW];
        sel_be    = bus.be[j*BE_W +: BE_W];
        sel_wdata = bus.wdata[j*DATA_W +: DATA_W];
        sel_we    = bus.we[j];
      end
    end
    sel_oob = 32'(sel_addr) >= DEPTH;
  end

  assign bus.gnt        = gnt;
  assign ram_address    = sel_addr;
  assign ram_byteenable = sel_be;
  assign ram_writedata  = sel_wdata;
  assign ram_write      = win_vld & sel_we;
  assign ram_chipselect = win_vld & ~sel_oob;

  always_comb begin
    last_d    = win_vld ? win : last_q;
    owner_d   = win_vld;
    hold_d    = '0;
    if (win_vld && lock_win) begin
      hold_d = (hold_q == HOLD_LIM) ? hold_q : hold_q + HW'(1);
    end
    tag_d     = '{id: win, is_read: ~sel_we, oob: sel_oob};
    tag_vld_d = win_vld;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q    <= ID_W'(NUM_REQ - 1);
      owner_q   <= 1'b0;
      hold_q    <= '0;
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      tag_q     <= tag_d;
      tag_vld_q <= tag_vld_d;
    end
  end

  // Out-of-range reads return zero instead of whatever the idle RAM port shows.
  always_comb begin
    bus.rvalid = '0;
    bus.rerr   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == tag_q.id) begin
        bus.rvalid[j] = tag_vld_q & tag_q.is_read;
        bus.rerr[j]   = tag_vld_q & tag_q.oob;
      end
    end
    bus.rdata = (tag_vld_q & tag_q.is_read & ~tag_q.oob) ? ram_readdata : '0;
  end

endmodule
